// File: rtl/nes_int_pkg.sv
// nes_int_pkg: shared types and vector addresses for the 6502-style interrupt controller.
package nes_int_pkg;
    typedef enum logic [1:0] {
        VEC_NONE = 2'b00,
        VEC_NMI  = 2'b01,
        VEC_RST  = 2'b10,
        VEC_IRQ  = 2'b11
    } vec_sel_t;
    typedef enum logic {IDLE, REQ} state_t;
    localparam logic [15:0] ADDR_NMI = 16'hFFFA;
    localparam logic [15:0] ADDR_RST = 16'hFFFC;
    localparam logic [15:0] ADDR_IRQ = 16'hFFFE;
    function automatic logic [15:0] vec_addr(vec_sel_t v);
        return v == VEC_NMI ? ADDR_NMI : v == VEC_RST ? ADDR_RST : v == VEC_IRQ ? ADDR_IRQ : 16'h0000;
    endfunction
endpackage

// File: rtl/nes_int_ctrl_if.sv
// nes_int_ctrl_if: CPU-side interrupt bus; master is the CPU/decoder, slave is the controller.
interface nes_int_ctrl_if
    import nes_int_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
);
    logic [NUM_IRQ-1:0] irq_n;
    logic               nmi_n;
    logic [NUM_IRQ-1:0] irq_en;
    logic               irq_mask;
    logic               poll;
    logic               int_ack;
    logic [NUM_IRQ-1:0] irq_clr;
    logic [NUM_IRQ-1:0] irq_edge;
    logic               int_out;
    logic               nmi_out;
    logic               irq_out;
    logic               rst_out;
    vec_sel_t           vec_sel;
    logic [ID_W-1:0]    src_id;
    logic [NUM_IRQ-1:0] pending;
    modport master (
        output irq_n, nmi_n, irq_en, irq_mask, poll, int_ack, irq_clr, irq_edge,
        input  int_out, nmi_out, irq_out, rst_out, vec_sel, src_id, pending
    );
    modport slave (
        input  irq_n, nmi_n, irq_en, irq_mask, poll, int_ack, irq_clr, irq_edge,
        output int_out, nmi_out, irq_out, rst_out, vec_sel, src_id, pending
    );
endinterface

// File: rtl/nes_int_sync.sv
// nes_int_sync: STAGES-deep synchroniser for an active-low line plus a one-cycle falling-edge pulse.
module nes_int_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_ph1,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              last_q;
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            sync_q <= '1;
            last_q <= 1'b1;
        end else begin
            sync_q <= STAGES'({sync_q, d_i});
            last_q <= q_o;
        end
    end
    assign q_o    = sync_q[STAGES-1];
    assign fall_o = last_q & ~q_o;
endmodule

// File: rtl/nes_int_ctrl.sv
// nes_int_ctrl: reset/NMI/IRQ arbiter presenting vector select and source ID at the CPU poll point.
// Optional INTC_EDGE_MODE_EN adds sticky per-channel edge-triggered IRQ pending bits.
module nes_int_ctrl
    import nes_int_pkg::*;
#(
    parameter int NUM_IRQ     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic        clk_ph1,
    input  logic        rst,
    nes_int_ctrl_if.slave bus
);
    logic [NUM_IRQ-1:0] irq_sync, irq_fall, pending;
    logic               nmi_sync, nmi_fall, nmi_pend_q, nmi_pend_d, nmi_ack, irq_req;
    logic [ID_W-1:0]    src_q, first_id;
    state_t             state_q;
    vec_sel_t           vec_q;
    logic               int_q, nmi_q, irq_q, rst_q;
    logic               unused_ok;

    genvar i;
    for (i = 0; i < NUM_IRQ; i++) begin : g_irq
        nes_int_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_ph1(clk_ph1), .rst(rst), .d_i(bus.irq_n[i]),
            .q_o(irq_sync[i]), .fall_o(irq_fall[i])
        );
    end
    nes_int_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk_ph1(clk_ph1), .rst(rst), .d_i(bus.nmi_n), .q_o(nmi_sync), .fall_o(nmi_fall)
    );

`ifdef INTC_EDGE_MODE_EN
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    // A fresh edge beats a simultaneous clear so no request is lost.
    assign pend_d = (irq_fall & bus.irq_edge) | (pend_q & ~bus.irq_clr);
    always_ff @(posedge clk_ph1) begin
        if (!rst) pend_q <= '0;
        else pend_q <= pend_d;
    end
    assign pending   = ((bus.irq_edge & pend_q) | (~bus.irq_edge & ~irq_sync)) & bus.irq_en;
    assign unused_ok = nmi_sync;
`else
    assign pending   = ~irq_sync & bus.irq_en;
    assign unused_ok = ^{bus.irq_edge, bus.irq_clr, irq_fall, nmi_sync};
`endif

    always_comb begin
        first_id = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) if (pending[k]) first_id = ID_W'(k);
    end

    assign irq_req    = |pending & ~bus.irq_mask;
    assign nmi_ack    = (state_q == REQ) & bus.int_ack & (vec_q == VEC_NMI);
    assign nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_ack);

    // Reset lands in REQ with the reset vector so the CPU runs its reset sequence first.
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            state_q    <= REQ;
            vec_q      <= VEC_RST;
            int_q      <= 1'b1;
            rst_q      <= 1'b1;
            nmi_q      <= 1'b0;
            irq_q      <= 1'b0;
            src_q      <= '0;
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_pend_q <= nmi_pend_d;
            case (state_q)
                IDLE: if (bus.poll && (nmi_pend_q || irq_req)) begin
                    state_q <= REQ;
                    int_q   <= 1'b1;
                    nmi_q   <= nmi_pend_q;
                    irq_q   <= ~nmi_pend_q;
                    vec_q   <= nmi_pend_q ? VEC_NMI : VEC_IRQ;
                    if (!nmi_pend_q) src_q <= first_id;
                end
                REQ: if (bus.int_ack) begin
                    state_q <= IDLE;
                    int_q   <= 1'b0;
                    nmi_q   <= 1'b0;
                    irq_q   <= 1'b0;
                    rst_q   <= 1'b0;
                    vec_q   <= VEC_NONE;
                end else if (vec_q == VEC_IRQ && nmi_pend_q) begin
                    vec_q <= VEC_NMI;
                    nmi_q <= 1'b1;
                    irq_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.int_out = int_q;
    assign bus.nmi_out = nmi_q;
    assign bus.irq_out = irq_q;
    assign bus.rst_out = rst_q;
    assign bus.vec_sel = vec_q;
    assign bus.src_id  = src_q;
    assign bus.pending = pending;
endmodule

// File: tb/tb_nes_int_ctrl.sv
// tb_nes_int_ctrl: directed checks of reset, IRQ arbitration, masking, NMI edge detection and hijack.
module tb_nes_int_ctrl;
    import nes_int_pkg::*;
    logic clk_ph1 = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   nmi_count;

    nes_int_ctrl_if #(.NUM_IRQ(4), .ID_W(2)) bus ();
    nes_int_ctrl #(.NUM_IRQ(4), .SYNC_STAGES(2), .ID_W(2)) dut (
        .clk_ph1(clk_ph1), .rst(rst), .bus(bus.slave)
    );

    always #5 clk_ph1 = ~clk_ph1;

    task automatic step(input int n);
        repeat (n) @(posedge clk_ph1);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic i, input logic n, input logic q, input logic r, input logic [1:0] v);
        check({tag, ".int"}, 32'(bus.int_out), 32'(i));
        check({tag, ".nmi"}, 32'(bus.nmi_out), 32'(n));
        check({tag, ".irq"}, 32'(bus.irq_out), 32'(q));
        check({tag, ".rst"}, 32'(bus.rst_out), 32'(r));
        check({tag, ".vec"}, 32'(bus.vec_sel), 32'(v));
    endtask

    initial begin
        rst = 1'b0;
        bus.irq_n = 4'hF; bus.nmi_n = 1'b1; bus.irq_en = 4'hF; bus.irq_mask = 1'b0;
        bus.poll = 1'b0; bus.int_ack = 1'b0; bus.irq_clr = 4'h0; bus.irq_edge = 4'h0;
        step(3);
        chk_out("reset", 1, 0, 0, 1, 2'b10);
        check("reset.src", 32'(bus.src_id), 0);
        check("reset.pending", 32'(bus.pending), 0);
        rst = 1'b1;
        step(5);
        chk_out("rst_persist", 1, 0, 0, 1, 2'b10);
        bus.int_ack = 1'b1; step(1); bus.int_ack = 1'b0;
        chk_out("rst_ack", 0, 0, 0, 0, 2'b00);

        bus.irq_n = 4'b1001; step(2);
        check("irq.pending", 32'(bus.pending), 32'h6);
        bus.poll = 1'b1; step(1); bus.poll = 1'b0;
        chk_out("irq", 1, 0, 1, 0, 2'b11);
        check("irq.src", 32'(bus.src_id), 1);
        bus.irq_n = 4'hF; step(1);
        chk_out("irq_no_retract", 1, 0, 1, 0, 2'b11);
        bus.int_ack = 1'b1; step(1); bus.int_ack = 1'b0;
        chk_out("irq_ack", 0, 0, 0, 0, 2'b00);

        bus.irq_n = 4'b1110; bus.irq_mask = 1'b1; step(2);
        check("mask.pending", 32'(bus.pending), 32'h1);
        bus.poll = 1'b1; step(1); bus.poll = 1'b0;
        check("masked.int", 32'(bus.int_out), 0);
        bus.int_ack = 1'b1; step(1); bus.int_ack = 1'b0;
        check("idle_ack.int", 32'(bus.int_out), 0);
        bus.irq_mask = 1'b0; bus.poll = 1'b1; bus.int_ack = 1'b1; step(1);
        bus.poll = 1'b0; bus.int_ack = 1'b0;
        chk_out("poll_ack", 1, 0, 1, 0, 2'b11);
        check("unmask.src", 32'(bus.src_id), 0);
        bus.irq_mask = 1'b1; step(1);
        chk_out("mask_in_req", 1, 0, 1, 0, 2'b11);
        bus.int_ack = 1'b1; step(1); bus.int_ack = 1'b0;
        chk_out("mask_ack", 0, 0, 0, 0, 2'b00);
        bus.irq_n = 4'hF; bus.irq_mask = 1'b0; step(3);

        bus.nmi_n = 1'b0; step(3);
        nmi_count = 0;
        for (int k = 0; k < 10; k++) begin
            bus.poll = 1'b1; step(1); bus.poll = 1'b0;
            if (bus.nmi_out && bus.vec_sel == VEC_NMI) nmi_count++;
            bus.int_ack = 1'b1; step(1); bus.int_ack = 1'b0;
            step(1);
        end
        check("nmi_held.count", 32'(nmi_count), 1);
        bus.nmi_n = 1'b1; step(3);
        bus.nmi_n = 1'b0; step(3);
        bus.poll = 1'b1; step(1); bus.poll = 1'b0;
        chk_out("nmi_rearm", 1, 1, 0, 0, 2'b01);
        bus.int_ack = 1'b1; step(1); bus.int_ack = 1'b0;
        chk_out("nmi_ack", 0, 0, 0, 0, 2'b00);

        bus.nmi_n = 1'b1; bus.irq_n = 4'b0111; step(3);
        bus.poll = 1'b1; step(1); bus.poll = 1'b0;
        chk_out("hj_irq", 1, 0, 1, 0, 2'b11);
        check("hj_irq.src", 32'(bus.src_id), 3);
        bus.nmi_n = 1'b0; step(3);
        check("hj_pre.vec", 32'(bus.vec_sel), 32'h3);
        step(1);
        chk_out("hijack", 1, 1, 0, 0, 2'b01);
        check("hijack.src", 32'(bus.src_id), 3);
        bus.int_ack = 1'b1; step(1); bus.int_ack = 1'b0;
        chk_out("hj_ack", 0, 0, 0, 0, 2'b00);
        bus.irq_n = 4'hF; step(3);
        bus.poll = 1'b1; step(1); bus.poll = 1'b0;
        check("hj_nmi_cleared.int", 32'(bus.int_out), 0);

`ifdef INTC_EDGE_MODE_EN
        bus.irq_edge = 4'b0100;
        bus.irq_n = 4'b1011; step(1); bus.irq_n = 4'hF; step(2);
        check("edge.pending", 32'(bus.pending), 32'h4);
        bus.poll = 1'b1; step(1); bus.poll = 1'b0;
        chk_out("edge_irq", 1, 0, 1, 0, 2'b11);
        check("edge.src", 32'(bus.src_id), 2);
        bus.int_ack = 1'b1; step(1); bus.int_ack = 1'b0;
        check("edge_sticky.pending", 32'(bus.pending), 32'h4);
        bus.irq_clr = 4'b0100; step(1); bus.irq_clr = 4'h0;
        check("edge_clr.pending", 32'(bus.pending), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nes_int_ctrl.md
Name: nes_int_ctrl

Overview:
Parametrised interrupt controller for the 6502-style CPU core. It replaces the fixed single-IRQ/single-NMI detector with NUM_IRQ maskable IRQ sources, one edge-detected NMI and a post-reset request. At the CPU's poll point it arbitrates reset, then NMI, then IRQ, and presents a vector select and source ID to the instruction decoder. It also supports NMI hijack of an IRQ sequence that has not yet been acknowledged.

Parameters:
NUM_IRQ, 4, number of active-low IRQ sources (1..16)
SYNC_STAGES, 2, synchroniser flops on every external interrupt input (≥1)
ID_W, $clog2(NUM_IRQ) (min 1), width of src_id

Ports:
clk_ph1  in  1  CPU phase-1 clock
rst  in  1  reset, synchronous, active-low; clock clk_ph1
irq_n  in  NUM_IRQ  IRQ request lines, active-low, level
nmi_n  in  1  NMI line, active-low, falling-edge
irq_en  in  NUM_IRQ  per-source enable
irq_mask  in  1  CPU P[2] (I flag); 1 blocks IRQs
poll  in  1  CPU last-cycle-of-instruction strobe; sample point
int_ack  in  1  CPU reached vector fetch; commits vector and clears request
irq_clr  in  NUM_IRQ  per-source pending clear (edge mode only)
irq_edge  in  NUM_IRQ  per-source edge-trigger select (edge mode only)
int_out  out  1  request interrupt sequence instead of next opcode
nmi_out  out  1  current request is NMI
irq_out  out  1  current request is IRQ
rst_out  out  1  current request is reset sequence
vec_sel  out  2  00=none, 01=NMI($FFFA), 10=RESET($FFFC), 11=IRQ($FFFE)
src_id  out  ID_W  lowest-index IRQ source latched at poll
pending  out  NUM_IRQ  live enabled-and-asserted IRQ vector

Behaviour:
- Reset (rst=0): all synchronisers = 1 (inactive), nmi_pend=0, edge pending bits=0, src_id=0, irq_out=0, nmi_out=0, rst_out=1, vec_sel=10, int_out=1. Reset request persists after rst deasserts until int_ack.
- Sync: each irq_n and nmi_n bit passes SYNC_STAGES flops. pending = ~irq_sync & irq_en (level channels).
- NMI: a 1→0 transition on synced nmi sets nmi_pend one cycle after the sync output. nmi_pend stays set until int_ack with vec_sel=01. A low held NMI line does not re-trigger; a new falling edge during service re-arms nmi_pend.
- States: IDLE, REQ. Outputs are registered.
- IDLE→REQ on poll=1 when request_any:
  - rst_out → vec 10
  - else nmi_pend → vec 01
  - else (|pending & ~irq_mask) → vec 11, src_id = lowest set index.
- In IDLE, poll=0 or no request keeps all outputs 0.
- REQ: int_out=1, vec_sel held.
- Hijack: in REQ with vec 11, if nmi_pend becomes set before int_ack, vec_sel switches to 01 the next cycle, with nmi_out=1 and irq_out=0. src_id is held.
- REQ→IDLE on int_ack:
  - int_out, nmi_out, irq_out and rst_out clear the next cycle.
  - NMI ack clears nmi_pend unless a new edge arrives in the same cycle; the new edge wins.
- IRQ deasserted while in REQ: the request is still serviced (no retraction). This is the documented 6502 behaviour.
- irq_mask change while in REQ is ignored; irq_mask is sampled only at poll.
- poll and int_ack asserted together in IDLE: poll is evaluated and int_ack is ignored.
- int_ack in IDLE: no effect.

Optional Feature:
INTC_EDGE_MODE_EN
- Defined: channel i with irq_edge[i]=1 sets a sticky pend[i] on a synced 1→0 edge. pending[i] = pend[i] & irq_en[i]. pend[i] clears on irq_clr[i]; an edge in the same cycle as the clear wins.
- Undefined: all channels are level-sensitive. irq_edge and irq_clr are ignored, and no pend flops are synthesised.

Decomposition:
- Package nes_int_pkg:
  - vec_sel_t enum VEC_NONE=2'b00, VEC_NMI=2'b01, VEC_RST=2'b10, VEC_IRQ=2'b11
  - state enum IDLE/REQ
  - vector address constants 16'hFFFA/FFFC/FFFE
- Sub-module nes_int_sync: SYNC_STAGES-deep synchroniser plus falling-edge pulse output. Instantiated once for NMI and NUM_IRQ times for IRQs.

Test Plan:
1. Release rst, poll=0 → int_out=1, rst_out=1, vec_sel=10 until int_ack; all outputs 0 the cycle after int_ack.
2. NUM_IRQ=4, irq_en=4'hF, irq_mask=0, irq_n=4'b1001, poll after 2-cycle sync → irq_out=1, vec_sel=11, src_id=1.
3. irq_mask=1 with irq_n=4'b1110, poll → int_out stays 0. Clear mask, poll → irq_out=1, src_id=0.
4. Hold nmi_n low for 10 polls with int_ack after each → exactly one NMI serviced. Toggle nmi_n high then low → second NMI serviced.
5. IRQ in REQ (vec 11), NMI edge 1 cycle before int_ack → vec_sel=01 and nmi_out=1 at int_ack; nmi_pend cleared after.
6. With INTC_EDGE_MODE_EN and irq_edge[2]=1: pulse irq_n[2] low for 1 cycle → pending[2] sticky through int_ack; irq_clr[2] → pending[2]=0 the next cycle.
